// File: rtl/sc_stream_pkg.sv
// Shared types and default widths for the stochastic-stream accumulator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sc_stream_pkg;

  // Default number of input bitstreams (one per generator output X).
  localparam int DEF_NUM_INPUTS = 4;

  // Default width of every counter and result field.
  localparam int DEF_CNT_W = 16;

  // Frame tracking state: idle, waiting for first done pulse, counting.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    COUNT = 2'd2
  } state_e;

endpackage

// File: rtl/sc_sat_ctr.sv
// Saturating up-counter with synchronous clear and parallel load.
// Latency: new value visible 1 cycle after clr/load/inc.
// Backpressure: none; holds at all-ones instead of wrapping.
module sc_sat_ctr
  import sc_stream_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear beats load beats increment; increment stops at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/sc_stream_acc.sv
// Per-frame ones counter for stochastic bitstreams (per stream, AND product, length).
// Latency: frame result visible 1 cycle after the gen_done cycle that closes it.
// Backpressure: single-entry result register; a frame closing while it is full is dropped and ovf set.
module sc_stream_acc
  import sc_stream_pkg::*;
#(
  parameter int NUM_INPUTS = DEF_NUM_INPUTS,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        stop,
  input  logic [NUM_INPUTS-1:0]       in_bits,
  input  logic                        gen_done,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_INPUTS*CNT_W-1:0] out_cnts,
  output logic [CNT_W-1:0]            out_and_cnt,
  output logic [CNT_W-1:0]            out_len,
  output logic                        busy,
  output logic                        ovf
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Frame tracking state.
  state_e state_q;
  state_e state_d;
  logic   stop_pend_q;
  logic   stop_pend_d;

  // Accumulator controls shared by every counter.
  logic acc_clr;
  logic acc_load;
  logic acc_inc;
  logic frame_close;
  logic all_ones;

  // Live accumulator values (the frame in progress).
  logic [NUM_INPUTS*CNT_W-1:0] acc_cnts;
  logic [CNT_W-1:0]            acc_and;
  logic [CNT_W-1:0]            acc_len;

  // Result register.
  logic                        out_valid_q;
  logic                        out_valid_d;
  logic                        ovf_q;
  logic                        ovf_d;
  logic [NUM_INPUTS*CNT_W-1:0] res_cnts_q;
  logic [NUM_INPUTS*CNT_W-1:0] res_cnts_d;
  logic [CNT_W-1:0]            res_and_q;
  logic [CNT_W-1:0]            res_and_d;
  logic [CNT_W-1:0]            res_len_q;
  logic [CNT_W-1:0]            res_len_d;
  logic                        drain;

  assign all_ones = &in_bits;

  // One saturating counter per input stream.
  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_stream
    sc_sat_ctr #(
      .CNT_W(CNT_W)
    ) u_ctr (
      .clk      (clk),
      .rst      (rst),
      .clr      (acc_clr),
      .load     (acc_load),
      .load_val ({{(CNT_W-1){1'b0}}, in_bits[i]}),
      .inc      (acc_inc & in_bits[i]),
      .cnt      (acc_cnts[i*CNT_W +: CNT_W])
    );
  end

  // Counter for the bitwise AND of all streams (the SC product).
  sc_sat_ctr #(
    .CNT_W(CNT_W)
  ) u_and_ctr (
    .clk      (clk),
    .rst      (rst),
    .clr      (acc_clr),
    .load     (acc_load),
    .load_val ({{(CNT_W-1){1'b0}}, all_ones}),
    .inc      (acc_inc & all_ones),
    .cnt      (acc_and)
  );

  // Frame length counter; a new frame always starts at length 1.
  sc_sat_ctr #(
    .CNT_W(CNT_W)
  ) u_len_ctr (
    .clk      (clk),
    .rst      (rst),
    .clr      (acc_clr),
    .load     (acc_load),
    .load_val (CNT_ONE),
    .inc      (acc_inc),
    .cnt      (acc_len)
  );

  // Next-state and accumulator control; done-cycle bits always open the next frame.
  always_comb begin
    state_d     = state_q;
    stop_pend_d = stop_pend_q;
    acc_clr     = 1'b0;
    acc_load    = 1'b0;
    acc_inc     = 1'b0;
    frame_close = 1'b0;
    case (state_q)
      IDLE: begin
        acc_clr     = 1'b1;
        stop_pend_d = 1'b0;
        if (start) begin
          state_d = SYNC;
        end
      end
      SYNC: begin
        if (stop) begin
          state_d = IDLE;
        end else if (gen_done) begin
          acc_load = 1'b1;
          state_d  = COUNT;
        end
      end
      COUNT: begin
        if (gen_done) begin
          frame_close = 1'b1;
          acc_load    = 1'b1;
          if (stop_pend_q || stop) begin
            state_d     = IDLE;
            stop_pend_d = 1'b0;
          end
        end else begin
          acc_inc = 1'b1;
          if (stop) begin
            stop_pend_d = 1'b1;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        stop_pend_d = 1'b0;
      end
    endcase
  end

  // Result register: load on close if empty or draining this cycle, else drop and flag.
  always_comb begin
    out_valid_d = out_valid_q;
    ovf_d       = ovf_q;
    res_cnts_d  = res_cnts_q;
    res_and_d   = res_and_q;
    res_len_d   = res_len_q;
    drain       = out_valid_q & out_ready;
    if (frame_close) begin
      if (!out_valid_q || drain) begin
        out_valid_d = 1'b1;
        res_cnts_d  = acc_cnts;
        res_and_d   = acc_and;
        res_len_d   = acc_len;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (drain) begin
      out_valid_d = 1'b0;
    end
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      stop_pend_q <= 1'b0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      res_cnts_q  <= '0;
      res_and_q   <= '0;
      res_len_q   <= '0;
    end else begin
      state_q     <= state_d;
      stop_pend_q <= stop_pend_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
      res_cnts_q  <= res_cnts_d;
      res_and_q   <= res_and_d;
      res_len_q   <= res_len_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_cnts    = res_cnts_q;
  assign out_and_cnt = res_and_q;
  assign out_len     = res_len_q;
  assign busy        = (state_q != IDLE);
  assign ovf         = ovf_q;

endmodule
